paddle_ctrl: RTL and testbench

- Upstream stage of the ball logic. Converts two raw player pushbuttons (up/down) into the three paddle cell positions `player1`, `player2` and `player3` on the 10-row x 30-column LED grid.
- Grid cells are numbered 1..300; row k (0..9) covers cells 30k+1..30k+30, and the player column is cell 30(k+1).
- The block synchronises, debounces and auto-repeats each button, then moves a 3-cell vertical paddle one row per step, saturating at the screen edges.

---
 rtl/paddle_if.sv | 21 ++
 rtl/paddle_ctrl.sv | 125 ++++++++++++
 tb/tb_paddle_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/paddle_if.sv
// Button, hold and paddle-position signals between the player input stage and the ball logic.
interface paddle_if;
  logic       btn_up;
  logic       btn_down;
  logic       hold;
  logic [8:0] player1;
  logic [8:0] player2;
  logic [8:0] player3;
  logic       moved;
  logic       at_limit;

  modport master (
    output btn_up, btn_down, hold,
    input  player1, player2, player3, moved, at_limit
  );

  modport slave (
    input  btn_up, btn_down, hold,
    output player1, player2, player3, moved, at_limit
  );
endinterface

// File: rtl/paddle_ctrl.sv
// Turns raw up/down buttons into a 3-cell vertical paddle on the player column.
// Repeat FSM, one per button (index 0 = up, 1 = down):
//   state     | meaning
//   ST_IDLE   | debounced button low, waiting for a press
//   ST_DELAY  | first step issued, waiting REPEAT_DELAY before auto-repeat
//   ST_REPEAT | auto-repeating, one step every REPEAT_RATE cycles
module paddle_ctrl #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [23:0] REPEAT_DELAY    = 24'd5000000,
  parameter logic [23:0] REPEAT_RATE     = 24'd2500000,
  parameter logic [3:0]  RESET_ROW       = 4'd4
) (
  input  logic     clk,
  input  logic     reset,
  paddle_if.slave  pif
);

  typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_REPEAT} rpt_state_e;

  logic [1:0]  sync1_q, sync1_d;
  logic [1:0]  sync2_q, sync2_d;
  logic [1:0]  deb_q, deb_d;
  logic [15:0] deb_cnt_q [2];
  logic [15:0] deb_cnt_d [2];
  logic [23:0] tmr_q [2];
  logic [23:0] tmr_d [2];
  rpt_state_e  st_q [2];
  rpt_state_e  st_d [2];
  logic [1:0]  req;
  logic        step_up_q, step_up_d;
  logic        step_dn_q, step_dn_d;
  logic [3:0]  row_q, row_d;
  logic        moved_q, moved_d;

  always_comb begin
    sync1_d = {pif.btn_down, pif.btn_up};
    sync2_d = sync1_q;
    deb_d   = deb_q;
    req     = '0;
    for (int i = 0; i < 2; i++) begin
      deb_cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (deb_cnt_q[i] == DEBOUNCE_CYCLES - 16'd1) deb_d[i] = sync2_q[i];
        else                                         deb_cnt_d[i] = deb_cnt_q[i] + 16'd1;
      end

      tmr_d[i] = '0;
      st_d[i]  = st_q[i];
      if (!deb_q[i]) begin
        st_d[i] = ST_IDLE;
      end else begin
        case (st_q[i])
          ST_IDLE: begin
            st_d[i] = ST_DELAY;
            req[i]  = 1'b1;
          end
          ST_DELAY: begin
            if (tmr_q[i] == REPEAT_DELAY - 24'd1) begin
              st_d[i] = ST_REPEAT;
              req[i]  = 1'b1;
            end else begin
              tmr_d[i] = tmr_q[i] + 24'd1;
            end
          end
          ST_REPEAT: begin
            if (tmr_q[i] == REPEAT_RATE - 24'd1) req[i]   = 1'b1;
            else                                 tmr_d[i] = tmr_q[i] + 24'd1;
          end
          default: st_d[i] = ST_IDLE;
        endcase
      end
    end

    // Simultaneous requests cancel; both buttons held or hold=1 drop the step entirely.
    step_up_d = req[0] & ~req[1] & ~(&deb_q) & ~pif.hold;
    step_dn_d = req[1] & ~req[0] & ~(&deb_q) & ~pif.hold;

    row_d   = row_q;
    moved_d = 1'b0;
    if (step_up_q && row_q != 4'd8) begin
      row_d   = row_q + 4'd1;
      moved_d = 1'b1;
    end else if (step_dn_q && row_q != 4'd1) begin
      row_d   = row_q - 4'd1;
      moved_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      deb_q     <= '0;
      step_up_q <= 1'b0;
      step_dn_q <= 1'b0;
      row_q     <= RESET_ROW;
      moved_q   <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        deb_cnt_q[i] <= '0;
        tmr_q[i]     <= '0;
        st_q[i]      <= ST_IDLE;
      end
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      deb_q     <= deb_d;
      step_up_q <= step_up_d;
      step_dn_q <= step_dn_d;
      row_q     <= row_d;
      moved_q   <= moved_d;
      for (int i = 0; i < 2; i++) begin
        deb_cnt_q[i] <= deb_cnt_d[i];
        tmr_q[i]     <= tmr_d[i];
        st_q[i]      <= st_d[i];
      end
    end
  end

  assign pif.player1  = {5'b0, row_q} * 9'd30;
  assign pif.player2  = ({5'b0, row_q} + 9'd1) * 9'd30;
  assign pif.player3  = ({5'b0, row_q} + 9'd2) * 9'd30;
  assign pif.moved    = moved_q;
  assign pif.at_limit = (row_q == 4'd1) || (row_q == 4'd8);

endmodule

// File: tb/tb_paddle_ctrl.sv
// Directed vector table plus hand-written timing sequences for paddle_ctrl.
module tb_paddle_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  paddle_if pif();

  paddle_ctrl #(
    .DEBOUNCE_CYCLES(16'd4),
    .REPEAT_DELAY   (24'd20),
    .REPEAT_RATE    (24'd8),
    .RESET_ROW      (4'd4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .pif  (pif.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic up;
    logic dn;
    logic hd;
    int   ncyc;
    int   p1;
    int   p2;
    int   p3;
    logic lim;
    int   moves;
  } vec_t;

  vec_t vecs[16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    pif.btn_up = 1'b0;
    pif.btn_down = 1'b0;
    pif.hold = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic run_mask(input int first, input int last, output logic [63:0] mask);
    mask = '0;
    for (int e = first; e <= last; e++) begin
      tick();
      if (pif.moved) mask[e] = 1'b1;
    end
  endtask

  initial begin
    logic [63:0] m1;
    logic [63:0] m2;
    int mv;

    // up, dn, hold, cycles, player1/2/3, at_limit, moved pulses
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 10, 150, 180, 210, 1'b0, 1};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 10, 150, 180, 210, 1'b0, 0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0,  3, 150, 180, 210, 1'b0, 0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 10, 150, 180, 210, 1'b0, 0};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 30, 150, 180, 210, 1'b0, 0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 10, 150, 180, 210, 1'b0, 0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 10, 120, 150, 180, 1'b0, 1};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 10, 120, 150, 180, 1'b0, 0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 10,  90, 120, 150, 1'b0, 1};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 10,  90, 120, 150, 1'b0, 0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 10,  60,  90, 120, 1'b0, 1};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 10,  60,  90, 120, 1'b0, 0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 10,  30,  60,  90, 1'b1, 1};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 10,  30,  60,  90, 1'b1, 0};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 10,  30,  60,  90, 1'b1, 0};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 10,  30,  60,  90, 1'b1, 0};

    pif.btn_up = 1'b0;
    pif.btn_down = 1'b0;
    pif.hold = 1'b0;

    do_reset();
    chk("reset_p1", pif.player1, 120);
    chk("reset_p2", pif.player2, 150);
    chk("reset_p3", pif.player3, 180);
    chk("reset_moved", pif.moved, 0);
    chk("reset_limit", pif.at_limit, 0);

    for (int v = 0; v < 16; v++) begin
      pif.btn_up = vecs[v].up;
      pif.btn_down = vecs[v].dn;
      pif.hold = vecs[v].hd;
      mv = 0;
      repeat (vecs[v].ncyc) begin
        tick();
        if (pif.moved) mv++;
      end
      chk($sformatf("vec%0d_p1", v), pif.player1, vecs[v].p1);
      chk($sformatf("vec%0d_p2", v), pif.player2, vecs[v].p2);
      chk($sformatf("vec%0d_p3", v), pif.player3, vecs[v].p3);
      chk($sformatf("vec%0d_limit", v), pif.at_limit, vecs[v].lim);
      chk($sformatf("vec%0d_moves", v), mv, vecs[v].moves);
    end

    // Press latency and auto-repeat cadence: moves at edges 8, 28, 36, 44; edge 52 saturates.
    do_reset();
    pif.btn_up = 1'b1;
    run_mask(1, 60, m1);
    chk("repeat_mask", m1, (64'd1 << 8) | (64'd1 << 28) | (64'd1 << 36) | (64'd1 << 44));
    chk("repeat_p1", pif.player1, 240);
    chk("repeat_p3", pif.player3, 300);
    chk("repeat_limit", pif.at_limit, 1);
    pif.btn_up = 1'b0;
    repeat (10) tick();

    // Hold discards the press step; first move after release of hold is the DELAY step.
    do_reset();
    pif.hold = 1'b1;
    pif.btn_down = 1'b1;
    run_mask(1, 15, m1);
    pif.hold = 1'b0;
    run_mask(16, 40, m2);
    chk("hold_mask", m1 | m2, (64'd1 << 28) | (64'd1 << 36));
    chk("hold_p2", pif.player2, 90);
    pif.btn_down = 1'b0;
    repeat (10) tick();

    // Reset lands on the edge where a REPEAT step would have applied.
    do_reset();
    pif.btn_up = 1'b1;
    repeat (35) tick();
    chk("pre_reset_p2", pif.player2, 210);
    reset = 1'b1;
    tick();
    chk("midrst_p2", pif.player2, 150);
    chk("midrst_moved", pif.moved, 0);
    reset = 1'b0;
    run_mask(1, 12, m1);
    chk("post_reset_mask", m1, 64'd1 << 8);
    chk("post_reset_p2", pif.player2, 180);
    pif.btn_up = 1'b0;
    repeat (10) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
